vga_out: RTL
============

VGA_OUT -- requirements
Module: vga_out

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, meaning vertical back porch in lines.
REQ-009 The block SHALL have parameter SYNC_POL, default 0, meaning the asserted level of hsync/vsync (0 = active-low).
REQ-010 The block SHALL have one clock and a synchronous, active-high reset; clock port clk, reset port rst.
REQ-011 clk  input  1  system clock.
REQ-012 rst  input  1  synchronous active-high reset.
REQ-013 pix_en  input  1  pixel-rate enable, one clk-cycle pulse per pixel.
REQ-014 r_in, g_in, b_in  input  8 each  colour of the pixel currently presented on x/y, produced combinationally by the colour mapper.
REQ-015 x  output  10  current horizontal count.
REQ-016 y  output  10  current vertical count.
REQ-017 active  output  1  high when x < H_ACTIVE and y < V_ACTIVE.
REQ-018 hsync, vsync  output  1 each  sync pulses to the display.
REQ-019 r_out, g_out, b_out  output  8 each  registered pixel colour to the display.
REQ-020 frame_start  output  1  one-cycle pulse marking output of pixel (0,0).

Function
REQ-021 Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-022 Horizontal counter hc SHALL advance by 1 only on clk edges with pix_en=1, and SHALL wrap from H_TOTAL-1 to 0.
REQ-023 Vertical counter vc SHALL advance by 1 only on the pix_en edge where hc wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-024 Counters SHALL hold their values on every edge with pix_en=0.
REQ-025 x and y SHALL equal hc and vc directly; active SHALL be derived combinationally from them.
REQ-026 On each pix_en edge, r_out/g_out/b_out SHALL register {r_in,g_in,b_in} if active=1, else 0x00/0x00/0x00.
REQ-027 Output latency: r_out/g_out/b_out/hsync/vsync SHALL lag x/y by exactly one pixel (one pix_en period).
REQ-028 On each pix_en edge, hsync SHALL register SYNC_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751 by default), else ~SYNC_POL.
REQ-029 On each pix_en edge, vsync SHALL register SYNC_POL when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491 by default), else ~SYNC_POL.
REQ-030 frame_start SHALL be 1 for exactly one clk cycle, namely the cycle after a pix_en edge sampled with hc=0 and vc=0; otherwise it SHALL be 0.
REQ-031 If pix_en is held high continuously, the block SHALL still run one pixel per clk with no missed wrap.
REQ-032 The rgb inputs SHALL be ignored (not sampled) during blanking and on edges with pix_en=0.

Reset
REQ-033 On a clk edge with rst=1 (regardless of pix_en), hc and vc SHALL become 0.
REQ-034 On a clk edge with rst=1, r_out/g_out/b_out SHALL become 0, hsync and vsync SHALL become ~SYNC_POL, and frame_start SHALL become 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame; the first pix_en after rst deasserts SHALL sample hc=0, vc=0 and produce a frame_start pulse.

Verification
REQ-036 Reset/idle: rst=1 for 3 cycles, then pix_en=0 for 10 cycles -> x=0, y=0, hsync=vsync=1, rgb_out=0, frame_start never 1.
REQ-037 Line timing: pix_en every 4th clk, count pix_en pulses -> hsync low for exactly 96 pixels, starting with the pixel after x=656; x wraps 799->0; y increments on the wrap.
REQ-038 Frame timing: run one full frame -> vsync low during y=490..491 (one-pixel lag); y wraps 524->0; frame_start pulses exactly once per 420000 pix_en.
REQ-039 Colour gating: r_in=0xFF, g_in=0x00, b_in=0xFF constant -> rgb_out = FF/00/FF one pixel after each active x/y; 00/00/00 one pixel after x=640..799 or y>=480.
REQ-040 Mid-frame reset: at x=300, y=200, pulse rst for 1 clk with pix_en=1 -> x=0, y=0 next cycle; rgb_out=0; frame_start pulses after the next pix_en.
REQ-041 Continuous enable: pix_en=1 always -> x advances every clk; frame period is 420000 clk; no counter glitch at wrap points.

Source files
------------

// File: rtl/vga_out.sv
// rtl/vga_out.sv - VGA raster timing generator with registered colour and sync outputs
// Counters give x/y for the colour mapper; outputs lag x/y by one pixel.
module vga_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out,
    output logic       frame_start
);
    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic POL     = (SYNC_POL != 0);

    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic [23:0] rgb_q;
    logic        hsync_q, vsync_q, frame_start_q;
    logic        hs_win, vs_win;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            if (hc_q == 10'(H_TOTAL - 1)) begin
                hc_d = '0;
                vc_d = (vc_q == 10'(V_TOTAL - 1)) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    assign active = (hc_q < 10'(H_ACTIVE)) && (vc_q < 10'(V_ACTIVE));
    assign hs_win = (hc_q >= 10'(H_ACTIVE + H_FP)) && (hc_q < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_win = (vc_q >= 10'(V_ACTIVE + V_FP)) && (vc_q < 10'(V_ACTIVE + V_FP + V_SYNC));

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q          <= '0;
            vc_q          <= '0;
            rgb_q         <= '0;
            hsync_q       <= ~POL;
            vsync_q       <= ~POL;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            // Pulse lasts one clk even when pix_en is a sparse strobe.
            frame_start_q <= pix_en && (hc_q == '0) && (vc_q == '0);
            if (pix_en) begin
                rgb_q   <= active ? {r_in, g_in, b_in} : 24'h0;
                hsync_q <= hs_win ? POL : ~POL;
                vsync_q <= vs_win ? POL : ~POL;
            end
        end
    end

    assign x           = hc_q;
    assign y           = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign r_out       = rgb_q[23:16];
    assign g_out       = rgb_q[15:8];
    assign b_out       = rgb_q[7:0];
    assign frame_start = frame_start_q;
endmodule
